// File: rtl/spi3w_frame_engine.sv
// spi3w_frame_engine: 3-wire SPI master serialising 16-bit register frames with per-channel chip selects
module spi3w_frame_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic       main_clk,
    input  logic       reg_reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_channel,
    input  logic       cmd_r1w0,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_channel,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_csA_n,
    output logic       spi_csB_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       sdio_oe_n
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
    state_t      state;
    logic [7:0]  cnt;
    logic [4:0]  bit_cnt;
    logic [14:0] sr;
    logic [7:0]  rx;
    logic        chan;
    logic        rd;
    logic        last;
    assign last = cnt == LAST;
    always_ff @(posedge main_clk) begin
        if (reg_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            sr          <= '0;
            rx          <= '0;
            chan        <= 1'b0;
            rd          <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_channel <= 1'b0;
            spi_sclk    <= 1'b0;
            spi_csA_n   <= 1'b1;
            spi_csB_n   <= 1'b1;
            spi_mosi    <= 1'b0;
            sdio_oe_n   <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            cnt       <= last ? '0 : cnt + 8'd1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (cmd_valid) begin
                        state     <= SETUP;
                        sr        <= {cmd_addr, cmd_wdata};
                        rx        <= '0;
                        chan      <= cmd_channel;
                        rd        <= cmd_r1w0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        spi_csA_n <= cmd_channel;
                        spi_csB_n <= !cmd_channel;
                        sdio_oe_n <= 1'b0;
                        spi_mosi  <= cmd_r1w0;
                    end
                end
                SETUP: if (last) begin
                    state    <= SHIFT;
                    spi_sclk <= 1'b1;
                    bit_cnt  <= '0;
                end
                SHIFT: if (last) begin
                    if (spi_sclk) begin
                        spi_sclk <= 1'b0;
                        spi_mosi <= sr[14];
                        sr       <= {sr[13:0], 1'b0};
                        // release SDIO to the slave once the address phase is out
                        if (rd && bit_cnt == 5'd7) sdio_oe_n <= 1'b1;
                    end else begin
                        if (rd && bit_cnt >= 5'd7 && bit_cnt <= 5'd14) rx <= {rx[6:0], spi_miso};
                        if (bit_cnt == 5'd15) state <= HOLD;
                        else begin
                            spi_sclk <= 1'b1;
                            bit_cnt  <= bit_cnt + 5'd1;
                        end
                    end
                end
                HOLD: if (last) begin
                    state       <= GAP;
                    spi_csA_n   <= 1'b1;
                    spi_csB_n   <= 1'b1;
                    sdio_oe_n   <= 1'b1;
                    spi_mosi    <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= rd ? rx : 8'h00;
                    rsp_channel <= chan;
                end
                GAP: if (last) begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi3w_frame_engine.sv
// tb_spi3w_frame_engine: directed table-driven bench for the 3-wire SPI frame engine at CLK_DIV 4 and 1
module tb_spi3w_frame_engine;
    logic       main_clk = 1'b0;
    logic       reg_reset = 1'b1;
    logic       cmd_valid4 = 1'b0, cmd_valid1 = 1'b0;
    logic       cmd_channel = 1'b0, cmd_r1w0 = 1'b0, spi_miso = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       ready4, rsp_valid4, rch4, busy4, sclk4, csa4, csb4, mosi4, oe4;
    logic       ready1, rsp_valid1, rch1, busy1, sclk1, csa1, csb1, mosi1, oe1;
    logic [7:0] rdata4, rdata1;
    logic       sel = 1'b0;
    logic       m_ready, m_rsp_valid, m_rch, m_busy, m_sclk, m_csA, m_csB, m_mosi, m_oe;
    logic [7:0] m_rdata;
    int         n_chk = 0, n_fail = 0;

    always #5 main_clk = ~main_clk;

    spi3w_frame_engine #(.CLK_DIV(4)) dut4 (
        .main_clk(main_clk), .reg_reset(reg_reset), .cmd_valid(cmd_valid4), .cmd_ready(ready4),
        .cmd_channel(cmd_channel), .cmd_r1w0(cmd_r1w0), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid4), .rsp_rdata(rdata4), .rsp_channel(rch4), .busy(busy4),
        .spi_sclk(sclk4), .spi_csA_n(csa4), .spi_csB_n(csb4), .spi_mosi(mosi4),
        .spi_miso(spi_miso), .sdio_oe_n(oe4));

    spi3w_frame_engine #(.CLK_DIV(1)) dut1 (
        .main_clk(main_clk), .reg_reset(reg_reset), .cmd_valid(cmd_valid1), .cmd_ready(ready1),
        .cmd_channel(cmd_channel), .cmd_r1w0(cmd_r1w0), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rdata1), .rsp_channel(rch1), .busy(busy1),
        .spi_sclk(sclk1), .spi_csA_n(csa1), .spi_csB_n(csb1), .spi_mosi(mosi1),
        .spi_miso(spi_miso), .sdio_oe_n(oe1));

    assign m_ready     = sel ? ready1 : ready4;
    assign m_rsp_valid = sel ? rsp_valid1 : rsp_valid4;
    assign m_rch       = sel ? rch1 : rch4;
    assign m_busy      = sel ? busy1 : busy4;
    assign m_sclk      = sel ? sclk1 : sclk4;
    assign m_csA       = sel ? csa1 : csa4;
    assign m_csB       = sel ? csb1 : csb4;
    assign m_mosi      = sel ? mosi1 : mosi4;
    assign m_oe        = sel ? oe1 : oe4;
    assign m_rdata     = sel ? rdata1 : rdata4;

    // slave: drives read data MSB first on each sclk fall after rising edge 8
    int         rise_n = 0;
    logic       prev_s = 1'b0;
    logic [7:0] slave_data = 8'h00;
    always @(negedge main_clk) begin
        if (m_csA && m_csB) begin
            rise_n   = 0;
            spi_miso = 1'b0;
        end else if (m_sclk && !prev_s) rise_n = rise_n + 1;
        else if (!m_sclk && prev_s && rise_n >= 8 && rise_n <= 15) spi_miso = slave_data[15 - rise_n];
        prev_s = m_sclk;
    end

    typedef struct {
        logic        sel, ch, rw, noise;
        logic [6:0]  addr;
        logic [7:0]  wdata, sdata;
        logic [15:0] exp_bits, mask, exp_oe;
        logic [7:0]  exp_rdata;
        int          exp_last, exp_rsp, exp_ready, ncyc;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_valid(input logic s, input logic v);
        if (s) cmd_valid1 = v;
        else cmd_valid4 = v;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int first_cs = 0, last_cs = 0, cs_cnt = 0, other_low = 0, rises = 0;
        int rsp_cnt = 0, rsp_c = 0, ready_c = 0;
        logic [15:0] bits = '0, oe = '0;
        logic [7:0] rd = '0;
        logic rch = 1'b0, prev = 1'b0, lowcs, other;
        sel = v.sel;
        slave_data = v.sdata;
        @(negedge main_clk);
        chk($sformatf("v%0d_ready_before", idx), m_ready, 1);
        chk($sformatf("v%0d_busy_before", idx), m_busy, 0);
        cmd_channel = v.ch;
        cmd_r1w0 = v.rw;
        cmd_addr = v.addr;
        cmd_wdata = v.wdata;
        set_valid(v.sel, 1'b1);
        @(posedge main_clk);
        #1 set_valid(v.sel, 1'b0);
        for (int c = 1; c <= v.ncyc; c++) begin
            @(negedge main_clk);
            lowcs = v.ch ? m_csB : m_csA;
            other = v.ch ? m_csA : m_csB;
            if (!lowcs) begin
                if (first_cs == 0) first_cs = c;
                last_cs = c;
                cs_cnt++;
            end
            if (!other) other_low++;
            if (m_sclk && !prev) begin
                rises++;
                bits = {bits[14:0], m_mosi};
                oe = {oe[14:0], m_oe};
            end
            prev = m_sclk;
            if (m_rsp_valid) begin
                rsp_cnt++;
                if (rsp_c == 0) begin
                    rsp_c = c;
                    rd = m_rdata;
                    rch = m_rch;
                end
            end
            if (m_ready && ready_c == 0) ready_c = c;
            if (v.noise && c + 1 < v.exp_ready) begin
                cmd_channel = 1'($urandom);
                cmd_r1w0 = 1'($urandom);
                cmd_addr = 7'($urandom);
                cmd_wdata = 8'($urandom);
                set_valid(v.sel, 1'($urandom_range(0, 1)));
            end else set_valid(v.sel, 1'b0);
        end
        chk($sformatf("v%0d_cs_first", idx), first_cs, 1);
        chk($sformatf("v%0d_cs_last", idx), last_cs, v.exp_last);
        chk($sformatf("v%0d_cs_count", idx), cs_cnt, v.exp_last);
        chk($sformatf("v%0d_other_cs_low", idx), other_low, 0);
        chk($sformatf("v%0d_sclk_rises", idx), rises, 16);
        chk($sformatf("v%0d_mosi_bits", idx), bits & v.mask, v.exp_bits & v.mask);
        chk($sformatf("v%0d_oe_pattern", idx), oe, v.exp_oe);
        chk($sformatf("v%0d_rsp_cycle", idx), rsp_c, v.exp_rsp);
        chk($sformatf("v%0d_rsp_count", idx), rsp_cnt, 1);
        chk($sformatf("v%0d_rsp_rdata", idx), rd, v.exp_rdata);
        chk($sformatf("v%0d_rsp_channel", idx), rch, v.ch);
        chk($sformatf("v%0d_ready_cycle", idx), ready_c, v.exp_ready);
        chk($sformatf("v%0d_rdata_held", idx), m_rdata, v.exp_rdata);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h05, 8'hA5, 8'h00, 16'h05A5, 16'hFFFF, 16'h0000, 8'h00, 136, 137, 141, 150};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'h12, 8'h55, 8'h3C, 16'h9200, 16'hFF00, 16'h00FF, 8'h3C, 136, 137, 141, 150};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'h7F, 8'h00, 8'hFF, 16'h7F00, 16'hFFFF, 16'h0000, 8'h00, 136, 137, 141, 150};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'h00, 8'hFF, 8'hC3, 16'h8000, 16'hFF00, 16'h00FF, 8'hC3, 136, 137, 141, 150};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'h05, 8'hA5, 8'h00, 16'h05A5, 16'hFFFF, 16'h0000, 8'h00, 34, 35, 36, 45};

        repeat (3) @(posedge main_clk);
        @(negedge main_clk);
        chk("rst_ready", ready4, 1);
        chk("rst_busy", busy4, 0);
        chk("rst_rsp_valid", rsp_valid4, 0);
        chk("rst_rdata", rdata4, 8'h00);
        chk("rst_rch", rch4, 0);
        chk("rst_sclk", sclk4, 0);
        chk("rst_csA", csa4, 1);
        chk("rst_csB", csb4, 1);
        chk("rst_mosi", mosi4, 0);
        chk("rst_oe", oe4, 1);
        chk("rst_d1_ready", ready1, 1);
        chk("rst_d1_cs", {csa1, csb1, sclk1, oe1}, 4'b1101);
        reg_reset = 1'b0;

        begin
            int rises = 0, rsp_n = 0, cs_low = 0;
            logic prev = 1'b0;
            sel = 1'b0;
            @(negedge main_clk);
            cmd_channel = 1'b0; cmd_r1w0 = 1'b0; cmd_addr = 7'h05; cmd_wdata = 8'hA5;
            cmd_valid4 = 1'b1;
            @(posedge main_clk);
            #1 cmd_valid4 = 1'b0;
            for (int c = 1; c <= 80 && rises < 6; c++) begin
                @(negedge main_clk);
                if (m_sclk && !prev) rises++;
                prev = m_sclk;
            end
            chk("mid_rst_reached_rise6", rises, 6);
            reg_reset = 1'b1;
            cmd_valid4 = 1'b1;
            cmd_addr = 7'h33;
            @(negedge main_clk);
            reg_reset = 1'b0;
            cmd_valid4 = 1'b0;
            chk("mid_rst_cs", {csa4, csb4}, 2'b11);
            chk("mid_rst_sclk", sclk4, 0);
            chk("mid_rst_oe", oe4, 1);
            chk("mid_rst_ready", ready4, 1);
            chk("mid_rst_mosi", mosi4, 0);
            @(negedge main_clk);
            chk("mid_rst_valid_ignored", busy4, 0);
            for (int c = 0; c < 160; c++) begin
                @(negedge main_clk);
                if (rsp_valid4) rsp_n++;
                if (!csa4 || !csb4) cs_low++;
            end
            chk("mid_rst_no_rsp", rsp_n, 0);
            chk("mid_rst_no_cs", cs_low, 0);
        end

        for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

        begin
            int ready_c = 0, low2 = 0, gap = 0, rsp_n = 0, rises = 0;
            int rc[2] = '{0, 0};
            logic [7:0] rdv[2] = '{8'h00, 8'h00};
            logic chv[2] = '{1'b0, 1'b0};
            logic [15:0] bits = '0;
            logic prev = 1'b0;
            sel = 1'b0;
            slave_data = 8'h3C;
            @(negedge main_clk);
            cmd_channel = 1'b0; cmd_r1w0 = 1'b0; cmd_addr = 7'h05; cmd_wdata = 8'hA5;
            cmd_valid4 = 1'b1;
            @(posedge main_clk);
            #1;
            cmd_channel = 1'b1; cmd_r1w0 = 1'b1; cmd_addr = 7'h12; cmd_wdata = 8'h00;
            for (int c = 1; c <= 300; c++) begin
                @(negedge main_clk);
                if (c < 137 && sclk4 && !prev) begin
                    rises++;
                    bits = {bits[14:0], mosi4};
                end
                prev = sclk4;
                if (!csa4 || !csb4) begin
                    if (ready_c != 0 && low2 == 0) low2 = c;
                end else if (low2 == 0) gap++;
                if (rsp_valid4) begin
                    if (rsp_n < 2) begin
                        rc[rsp_n] = c;
                        rdv[rsp_n] = rdata4;
                        chv[rsp_n] = rch4;
                    end
                    rsp_n++;
                end
                if (ready_c != 0 && c == ready_c + 1) cmd_valid4 = 1'b0;
                if (ready4 && ready_c == 0) ready_c = c;
            end
            cmd_valid4 = 1'b0;
            chk("b2b_ready_cycle", ready_c, 141);
            chk("b2b_second_cs_low", low2, 142);
            chk("b2b_cs_gap", gap, 5);
            chk("b2b_first_bits", bits, 16'h05A5);
            chk("b2b_first_rises", rises, 16);
            chk("b2b_rsp_count", rsp_n, 2);
            chk("b2b_rsp0_cycle", rc[0], 137);
            chk("b2b_rsp0_rdata", rdv[0], 8'h00);
            chk("b2b_rsp0_ch", chv[0], 0);
            chk("b2b_rsp1_cycle", rc[1], 278);
            chk("b2b_rsp1_rdata", rdv[1], 8'h3C);
            chk("b2b_rsp1_ch", chv[1], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
